// File: rtl/display_msg_if.sv
// display_msg_if: event-pulse inputs and display-status outputs of the message scheduler
// Ports: hit_p/fail_p/win_p/turn_p (game logic -> scheduler); msg_code, msg_valid, busy,
// fifo_count, drop_cnt, blink (scheduler -> display/game). FIFO_DEPTH must match the scheduler.
interface display_msg_if #(
  parameter int FIFO_DEPTH = 4
);
  logic hit_p;
  logic fail_p;
  logic win_p;
  logic turn_p;
  logic [2:0] msg_code;
  logic msg_valid;
  logic busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [7:0] drop_cnt;
  logic blink;
  modport master (
    output hit_p, fail_p, win_p, turn_p,
    input msg_code, msg_valid, busy, fifo_count, drop_cnt, blink
  );
  modport slave (
    input hit_p, fail_p, win_p, turn_p,
    output msg_code, msg_valid, busy, fifo_count, drop_cnt, blink
  );
endinterface

// File: rtl/display_msg_scheduler.sv
// display_msg_scheduler: queues game-event pulses and shows each on the 7-seg display for a hold time
// Ports: clk, rst (sync, active high), bus (display_msg_if.slave: event pulses in; msg_code, msg_valid,
// busy, fifo_count, drop_cnt, blink out). Define DISP_BLINK_EN to enable segment blinking.
module display_msg_scheduler #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input logic clk,
  input logic rst,
  display_msg_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] HOLD_LD = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LD = GAP_CYCLES > 0 ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [1:0] IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2, LOCKED = 2'd3;
  localparam logic [2:0] C_HIT = 3'd1, C_FAIL = 3'd2, C_WIN = 3'd3, C_TURN = 3'd4;
  if (HOLD_CYCLES < 1) $error("HOLD_CYCLES must be >= 1");
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) $error("FIFO_DEPTH must be a power of 2, >= 2");
  if (BLINK_CYCLES < 1) $error("BLINK_CYCLES must be >= 1");
  logic [1:0] state;
  logic [31:0] timer;
  logic [2:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] count;
  logic [2:0] code;
  logic valid;
  logic [7:0] drops;
  logic live, win, full, push, load, pop;
  logic [2:0] sel;
  logic [1:0] n_ev, n_drop;
  logic [8:0] drop_sum;
  // live: events may be captured this cycle (a win or LOCKED discards them uncounted)
  always_comb begin
    live = state != LOCKED && !bus.win_p;
    win = state != LOCKED && bus.win_p;
    sel = bus.hit_p ? C_HIT : bus.fail_p ? C_FAIL : bus.turn_p ? C_TURN : 3'd0;
    n_ev = 2'(bus.hit_p) + 2'(bus.fail_p) + 2'(bus.turn_p);
    full = count == CW'(FIFO_DEPTH);
    push = live && sel != 3'd0 && !full;
    n_drop = (!live || n_ev == 2'd0) ? 2'd0 : n_ev - 2'd1 + 2'(full);
    drop_sum = {1'b0, drops} + 9'(n_drop);
    load = state == IDLE || (state == SHOW && timer == 0 && GAP_CYCLES == 0);
    pop = load && count != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
      code <= '0;
      valid <= 1'b0;
      drops <= '0;
    end else if (win) begin
      state <= LOCKED;
      timer <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
      code <= C_WIN;
      valid <= 1'b1;
    end else begin
      drops <= drop_sum > 9'd255 ? 8'd255 : drop_sum[7:0];
      if (push) begin
        mem[wr] <= sel;
        wr <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (load) begin
        state <= pop ? SHOW : IDLE;
        code <= pop ? mem[rd] : 3'd0;
        valid <= pop;
        timer <= pop ? HOLD_LD : 32'd0;
      end else if (state == SHOW) begin
        state <= timer == 0 ? GAP : SHOW;
        code <= timer == 0 ? 3'd0 : code;
        valid <= timer != 0;
        timer <= timer == 0 ? GAP_LD : timer - 1;
      end else if (state == GAP) begin
        state <= timer == 0 ? IDLE : GAP;
        timer <= timer == 0 ? 32'd0 : timer - 1;
      end
    end
  end
`ifdef DISP_BLINK_EN
  localparam logic [31:0] BLINK_LD = 32'(BLINK_CYCLES - 1);
  logic [31:0] bcnt;
  logic blink_q;
  // restarts at 0 on every new message or lock; runs only while staying in SHOW or LOCKED
  always_ff @(posedge clk) begin
    if (rst || win || pop || !((state == SHOW && timer != 0) || state == LOCKED)) begin
      bcnt <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt <= bcnt == BLINK_LD ? 32'd0 : bcnt + 1;
      blink_q <= bcnt == BLINK_LD ? ~blink_q : blink_q;
    end
  end
  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif
  assign bus.msg_code = code;
  assign bus.msg_valid = valid;
  assign bus.busy = state != IDLE || count != '0;
  assign bus.fifo_count = count;
  assign bus.drop_cnt = drops;
endmodule

// File: tb/tb_display_msg_scheduler.sv
// tb_display_msg_scheduler: directed self-checking bench; dut a uses GAP_CYCLES=2, dut b GAP_CYCLES=0
module tb_display_msg_scheduler;
`ifdef DISP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hit = 1'b0, fail = 1'b0, win = 1'b0, turn = 1'b0, use_b = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  display_msg_if #(.FIFO_DEPTH(2)) ia ();
  display_msg_if #(.FIFO_DEPTH(2)) ib ();
  assign ia.hit_p = hit && !use_b;
  assign ia.fail_p = fail && !use_b;
  assign ia.win_p = win && !use_b;
  assign ia.turn_p = turn && !use_b;
  assign ib.hit_p = hit && use_b;
  assign ib.fail_p = fail && use_b;
  assign ib.win_p = win && use_b;
  assign ib.turn_p = turn && use_b;
  display_msg_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .FIFO_DEPTH(2), .BLINK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  display_msg_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .FIFO_DEPTH(2), .BLINK_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );
  logic [2:0] code_o;
  logic valid_o, busy_o, blink_o;
  logic [1:0] cnt_o;
  logic [7:0] drop_o;
  assign code_o = use_b ? ib.msg_code : ia.msg_code;
  assign valid_o = use_b ? ib.msg_valid : ia.msg_valid;
  assign busy_o = use_b ? ib.busy : ia.busy;
  assign blink_o = use_b ? ib.blink : ia.blink;
  assign cnt_o = use_b ? ib.fifo_count : ia.fifo_count;
  assign drop_o = use_b ? ib.drop_cnt : ia.drop_cnt;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic h, input logic f, input logic w, input logic t);
    hit = h;
    fail = f;
    win = w;
    turn = t;
    step();
    hit = 1'b0;
    fail = 1'b0;
    win = 1'b0;
    turn = 1'b0;
  endtask
  task automatic show(input int c, input int first, input int last);
    for (int i = first; i < last; i++) begin
      step();
      check("show_code", code_o, c);
      check("show_valid", valid_o, 1);
      check("show_blink", blink_o, BLINK_ON ? (i / 2) % 2 : 0);
    end
  endtask
  task automatic blank(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      step();
      check("blank_code", code_o, 0);
      check("blank_valid", valid_o, 0);
      check("blank_busy", busy_o, b);
      check("blank_blink", blink_o, 0);
    end
  endtask
  task automatic idle_state(input string tag);
    check({tag, "_code"}, code_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_fifo"}, cnt_o, 0);
    check({tag, "_drop"}, drop_o, 0);
    check({tag, "_blink"}, blink_o, 0);
  endtask
  initial begin
    hit = 1'b1;
    step();
    step();
    step();
    hit = 1'b0;
    rst = 1'b0;
    idle_state("rst");
    step();
    idle_state("post_rst");
    pulse(1, 0, 0, 0);
    check("single_fifo", cnt_o, 1);
    check("single_valid0", valid_o, 0);
    check("single_busy", busy_o, 1);
    show(1, 0, 4);
    blank(2, 1);
    blank(1, 0);
    pulse(1, 1, 0, 0);
    check("pair_fifo", cnt_o, 1);
    check("pair_drop", drop_o, 1);
    pulse(0, 0, 0, 1);
    check("pair_code", code_o, 1);
    check("pair_fifo2", cnt_o, 1);
    show(1, 1, 4);
    blank(3, 1);
    show(4, 0, 4);
    blank(2, 1);
    blank(1, 0);
    check("pair_drop_end", drop_o, 1);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    check("burst_code", code_o, 1);
    pulse(0, 0, 0, 1);
    check("burst_fifo_mid", cnt_o, 2);
    pulse(0, 1, 0, 0);
    check("burst_fifo_full", cnt_o, 2);
    check("burst_drop", drop_o, 2);
    show(1, 3, 4);
    blank(3, 1);
    show(2, 0, 4);
    blank(3, 1);
    show(4, 0, 4);
    blank(2, 1);
    blank(1, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    check("win_pre_code", code_o, 1);
    check("win_pre_fifo", cnt_o, 1);
    pulse(0, 0, 1, 1);
    check("win_code", code_o, 3);
    check("win_valid", valid_o, 1);
    check("win_fifo", cnt_o, 0);
    check("win_busy", busy_o, 1);
    check("win_drop", drop_o, 2);
    check("win_blink", blink_o, 0);
    for (int i = 1; i < 5; i++) begin
      if (i == 1) pulse(1, 1, 0, 0);
      else step();
      check("lock_code", code_o, 3);
      check("lock_valid", valid_o, 1);
      check("lock_fifo", cnt_o, 0);
      check("lock_drop", drop_o, 2);
      check("lock_blink", blink_o, BLINK_ON ? (i / 2) % 2 : 0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_state("unlock");
    step();
    idle_state("unlock_idle");
    hit = 1'b1;
    fail = 1'b1;
    turn = 1'b1;
    for (int i = 0; i < 150; i++) step();
    hit = 1'b0;
    fail = 1'b0;
    turn = 1'b0;
    check("drop_sat", drop_o, 255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    use_b = 1'b1;
    step();
    idle_state("b_idle");
    pulse(1, 0, 0, 0);
    check("b_fifo", cnt_o, 1);
    pulse(0, 0, 0, 1);
    check("b_code", code_o, 1);
    check("b_valid", valid_o, 1);
    check("b_blink", blink_o, 0);
    show(1, 1, 4);
    show(4, 0, 4);
    blank(1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
